// File: rtl/button_events.sv
// Turns a clean synchronous button level into one-cycle press/click/release/long/repeat pulses.
// Latency 1 cycle (every output registered); no backpressure, so a pulse is lost if not sampled.
module button_events #(
  parameter int CNT_W      = 26,
  parameter int LONG_LEN   = 50000000,
  parameter int REPEAT_LEN = 10000000,
  parameter bit REPEAT_EN  = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic       i_btn,
  output logic       o_press,
  output logic       o_release,
  output logic       o_click,
  output logic       o_long_press,
  output logic       o_repeat,
  output logic       o_held,
  output logic [7:0] o_rep_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESSED,
    S_HELD,
    S_WAIT_REL
  } state_t;

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_LEN - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_LEN - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_rep_count;
  logic [7:0]       w_rep_count_nxt;
  logic             r_press, r_release, r_click, r_long_press, r_repeat, r_held;
  logic             w_press, w_release, w_click, w_long_press, w_repeat, w_held;

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rep_count_nxt = r_rep_count;
    w_press         = 1'b0;
    w_release       = 1'b0;
    w_click         = 1'b0;
    w_long_press    = 1'b0;
    w_repeat        = 1'b0;

    // A disabled block parks silently; a button still down must be released before it counts again.
    if (!i_enable) begin
      w_state_nxt = i_btn ? S_WAIT_REL : S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_btn) begin
            w_state_nxt     = S_PRESSED;
            w_cnt_nxt       = '0;
            w_rep_count_nxt = 8'd0;
            w_press         = 1'b1;
          end
        end
        S_PRESSED: begin
          if (!i_btn) begin
            w_state_nxt = S_IDLE;
            w_release   = 1'b1;
            w_click     = 1'b1;
          end else if (r_cnt == LONG_TC) begin
            w_state_nxt  = S_HELD;
            w_cnt_nxt    = '0;
            w_long_press = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_HELD: begin
          if (!i_btn) begin
            w_state_nxt = S_IDLE;
            w_release   = 1'b1;
          end else if (r_cnt == REP_TC) begin
            w_cnt_nxt = '0;
            if (REPEAT_EN) begin
              w_repeat        = 1'b1;
              w_rep_count_nxt = (r_rep_count == 8'hFF) ? r_rep_count : r_rep_count + 8'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        S_WAIT_REL: begin
          if (!i_btn) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    w_held = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_HELD);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rep_count  <= 8'd0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
      r_click      <= 1'b0;
      r_long_press <= 1'b0;
      r_repeat     <= 1'b0;
      r_held       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rep_count  <= w_rep_count_nxt;
      r_press      <= w_press;
      r_release    <= w_release;
      r_click      <= w_click;
      r_long_press <= w_long_press;
      r_repeat     <= w_repeat;
      r_held       <= w_held;
    end
  end

  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_click      = r_click;
  assign o_long_press = r_long_press;
  assign o_repeat     = r_repeat;
  assign o_held       = r_held;
  assign o_rep_count  = r_rep_count;

endmodule

// File: tb/tb_button_events.sv
// Bench for button_events: three instances (8/4 repeat on, 8/4 repeat off, 2/2 repeat on)
// share stimulus and are compared every cycle against an elapsed-hold-time model.
module tb_button_events;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic btn = 1'b0;

  logic [2:0] w_p, w_r, w_c, w_l, w_rp, w_h;
  logic [7:0] w_rc [3];

  always #5 clk = ~clk;

  button_events #(.CNT_W(8), .LONG_LEN(8), .REPEAT_LEN(4), .REPEAT_EN(1'b1)) u_a (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_btn(btn),
    .o_press(w_p[0]), .o_release(w_r[0]), .o_click(w_c[0]), .o_long_press(w_l[0]),
    .o_repeat(w_rp[0]), .o_held(w_h[0]), .o_rep_count(w_rc[0]));

  button_events #(.CNT_W(8), .LONG_LEN(8), .REPEAT_LEN(4), .REPEAT_EN(1'b0)) u_b (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_btn(btn),
    .o_press(w_p[1]), .o_release(w_r[1]), .o_click(w_c[1]), .o_long_press(w_l[1]),
    .o_repeat(w_rp[1]), .o_held(w_h[1]), .o_rep_count(w_rc[1]));

  button_events #(.CNT_W(4), .LONG_LEN(2), .REPEAT_LEN(2), .REPEAT_EN(1'b1)) u_c (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_btn(btn),
    .o_press(w_p[2]), .o_release(w_r[2]), .o_click(w_c[2]), .o_long_press(w_l[2]),
    .o_repeat(w_rp[2]), .o_held(w_h[2]), .o_rep_count(w_rc[2]));

  int p_long [3] = '{8, 8, 2};
  int p_rep  [3] = '{4, 4, 2};
  int p_ren  [3] = '{1, 0, 1};

  // Model: 0 idle, 1 active (button counted as down), 2 waiting for release after disable.
  int m_mode [3];
  int m_h    [3];
  int m_rc   [3];
  bit m_lf   [3];
  bit m_p [3], m_r [3], m_c [3], m_l [3], m_rp [3], m_held [3];

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic en, btn, p, r, c, l, rp, h;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 0; m_h[i] = 0; m_rc[i] = 0; m_lf[i] = 1'b0;
      m_p[i] = 0; m_r[i] = 0; m_c[i] = 0; m_l[i] = 0; m_rp[i] = 0; m_held[i] = 0;
    end
  endfunction

  function automatic void model_step(input int i);
    m_p[i] = 0; m_r[i] = 0; m_c[i] = 0; m_l[i] = 0; m_rp[i] = 0;
    if (!en) begin
      m_mode[i] = btn ? 2 : 0;
    end else if (m_mode[i] == 0) begin
      if (btn) begin
        m_mode[i] = 1; m_h[i] = 0; m_lf[i] = 1'b0; m_rc[i] = 0; m_p[i] = 1;
      end
    end else if (m_mode[i] == 1) begin
      if (!btn) begin
        m_mode[i] = 0; m_r[i] = 1; m_c[i] = !m_lf[i];
      end else begin
        m_h[i]++;
        if (m_h[i] == p_long[i]) begin
          m_l[i] = 1; m_lf[i] = 1'b1;
        end else if (m_h[i] > p_long[i] && ((m_h[i] - p_long[i]) % p_rep[i]) == 0 && p_ren[i] != 0) begin
          m_rp[i] = 1;
          if (m_rc[i] < 255) m_rc[i]++;
        end
      end
    end else if (!btn) begin
      m_mode[i] = 0;
    end
    m_held[i] = (m_mode[i] == 1);
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d_press", i),      int'(w_p[i]),  int'(m_p[i]));
      check($sformatf("u%0d_release", i),    int'(w_r[i]),  int'(m_r[i]));
      check($sformatf("u%0d_click", i),      int'(w_c[i]),  int'(m_c[i]));
      check($sformatf("u%0d_long_press", i), int'(w_l[i]),  int'(m_l[i]));
      check($sformatf("u%0d_repeat", i),     int'(w_rp[i]), int'(m_rp[i]));
      check($sformatf("u%0d_held", i),       int'(w_h[i]),  int'(m_held[i]));
      check($sformatf("u%0d_rep_count", i),  int'(w_rc[i]), m_rc[i]);
    end
  endtask

  // Inputs change only at negedge; model steps on the posedge, outputs are compared at negedge.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    check_all();
  endtask

  function automatic vec_t mkv(input logic e, input logic b, input logic p, input logic r,
                               input logic c, input logic l, input logic rp, input logic h);
    vec_t v;
    v = '{en: e, btn: b, p: p, r: r, c: c, l: l, rp: rp, h: h};
    return v;
  endfunction

  initial begin
    logic [31:0] long_mask, rep_mask_a, rep_mask_b;
    int seen_press, rep_tail;

    // Short press: press 1 cycle after rise, held 3 cycles, release+click after fall.
    vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mkv(1, 1, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(1, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0));
    // Race: fall lands on the terminal-count edge, so release+click and no long_press.
    vecs.push_back(mkv(1, 1, 1, 0, 0, 0, 0, 1));
    for (int k = 0; k < 7; k++) vecs.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(1, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0));

    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of a hold.
    btn = 1'b1;
    tick();
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check("reset_async_held_a", int'(w_h[0]), 0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("reset_restart_press_a", int'(w_p[0]), 1);
    btn = 1'b0;
    tick();
    tick();

    foreach (vecs[n]) begin
      en = vecs[n].en;
      btn = vecs[n].btn;
      tick();
      check($sformatf("vec%0d_press", n),   int'(w_p[0]),  int'(vecs[n].p));
      check($sformatf("vec%0d_release", n), int'(w_r[0]),  int'(vecs[n].r));
      check($sformatf("vec%0d_click", n),   int'(w_c[0]),  int'(vecs[n].c));
      check($sformatf("vec%0d_long", n),    int'(w_l[0]),  int'(vecs[n].l));
      check($sformatf("vec%0d_repeat", n),  int'(w_rp[0]), int'(vecs[n].rp));
      check($sformatf("vec%0d_held", n),    int'(w_h[0]),  int'(vecs[n].h));
    end

    // Long hold: long_press at t+8, repeats at t+12/16/20 (none with repeat disabled).
    long_mask = '0; rep_mask_a = '0; rep_mask_b = '0;
    btn = 1'b1;
    for (int t = 0; t <= 20; t++) begin
      tick();
      if (w_l[0]) long_mask[t] = 1'b1;
      if (w_rp[0]) rep_mask_a[t] = 1'b1;
      if (w_rp[1]) rep_mask_b[t] = 1'b1;
    end
    check("long_hold_long_at", int'(long_mask), int'(32'h0000_0100));
    check("long_hold_repeat_at", int'(rep_mask_a), int'(32'h0011_1000));
    check("long_hold_norepeat_b", int'(rep_mask_b), 0);
    check("long_hold_rep_count_a", int'(w_rc[0]), 3);
    check("long_hold_rep_count_b", int'(w_rc[1]), 0);
    btn = 1'b0;
    tick();
    check("long_release_a", int'(w_r[0]), 1);
    check("long_noclick_a", int'(w_c[0]), 0);
    tick();
    check("rep_count_kept_a", int'(w_rc[0]), 3);

    // Enable drop mid-hold, then re-enable with button still down.
    btn = 1'b1;
    tick();
    repeat (3) tick();
    en = 1'b0;
    tick();
    check("disable_held_a", int'(w_h[0]), 0);
    repeat (3) tick();
    en = 1'b1;
    seen_press = 0;
    repeat (4) begin
      tick();
      seen_press += int'(w_p[0]);
    end
    check("reenable_no_press_a", seen_press, 0);
    check("reenable_no_release_a", int'(w_r[0]), 0);
    btn = 1'b0;
    tick();
    btn = 1'b1;
    tick();
    check("repress_press_a", int'(w_p[0]), 1);

    // Saturation on the 2/2 instance.
    btn = 1'b0;
    tick();
    btn = 1'b1;
    rep_tail = 0;
    for (int t = 0; t < 600; t++) begin
      tick();
      if (t >= 580) rep_tail += int'(w_rp[2]);
    end
    check("sat_rep_count_c", int'(w_rc[2]), 255);
    check("sat_repeat_continues_c", rep_tail, 10);
    btn = 1'b0;
    tick();

    // Random run against the model.
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 11) == 0) btn = ~btn;
      if (en && $urandom_range(0, 99) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
